// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO.
//   Configurable width/depth, registered occupancy count, programmable
//   almost-full/almost-empty thresholds, sticky overflow/underflow flags,
//   and a selectable first-word-fall-through read mode.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   Data_in, W_EN      write data / write request
//   R_EN               read request (pop in FWFT mode)
//   ERR_CLR            clears OVERFLOW/UNDERFLOW
//   Data_out, R_VALID  read data and its valid qualifier
//   FULL_flag, EMPTY_flag, ALMOST_FULL, ALMOST_EMPTY  status decoded from COUNT
//   COUNT              occupancy 0..DEPTH
//   OVERFLOW/UNDERFLOW sticky error flags
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  W_EN,
  input  logic                  R_EN,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  R_VALID,
  output logic                  FULL_flag,
  output logic                  EMPTY_flag,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is decoded purely from the registered count, so it changes
  // in the same cycle as COUNT.
  assign FULL_flag    = (COUNT == DEPTH_C);
  assign EMPTY_flag   = (COUNT == '0);
  assign ALMOST_FULL  = (COUNT >= AF_C);
  assign ALMOST_EMPTY = (COUNT <= AE_C);

  // Acceptance uses the pre-edge flags: when full a simultaneous read still
  // drains, when empty a simultaneous write still fills.
  assign wr_acc = W_EN & ~FULL_flag;
  assign rd_acc = R_EN & ~EMPTY_flag;

  // Storage is never reset; writes are blocked during reset.
  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) begin
      mem[wr_ptr] <= Data_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      COUNT     <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
      // A new error in the same cycle as ERR_CLR keeps the flag set.
      OVERFLOW  <= (W_EN & FULL_flag)  | (OVERFLOW  & ~ERR_CLR);
      UNDERFLOW <= (R_EN & EMPTY_flag) | (UNDERFLOW & ~ERR_CLR);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is always presented; R_EN only acknowledges it.
      assign Data_out = mem[rd_ptr];
      assign R_VALID  = ~EMPTY_flag;
    end else begin : g_std
      always_ff @(posedge CLK) begin
        if (RST) begin
          Data_out <= '0;
          R_VALID  <= 1'b0;
        end else begin
          R_VALID <= rd_acc;
          if (rd_acc) Data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO buffer for the datapath. It is the successor of the fixed 8-bit x 16 FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It is used wherever producer and consumer share one clock, so no pointer synchronisers or Gray coding are needed.

Parameters:
DATA_WIDTH, 8, width of each stored word.
DEPTH, 16, number of entries; must be a power of 2 and >= 4.
ADDR_WIDTH, $clog2(DEPTH), pointer/address width; derived, do not override.
AF_THRESH, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_THRESH; legal range 1..DEPTH.
AE_THRESH, 2, ALMOST_EMPTY asserts when COUNT <= AE_THRESH; legal range 0..DEPTH-1.
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
CLK  input  1  single clock; all state updates on rising edge.
RST  input  1  reset; synchronous, active-high.
Data_in  input  DATA_WIDTH  write data.
W_EN  input  1  write request.
R_EN  input  1  read request (pop in FWFT mode).
ERR_CLR  input  1  clears OVERFLOW/UNDERFLOW.
Data_out  output  DATA_WIDTH  read data.
R_VALID  output  1  Data_out holds valid read data.
FULL_flag  output  1  COUNT == DEPTH.
EMPTY_flag  output  1  COUNT == 0.
ALMOST_FULL  output  1  COUNT >= AF_THRESH.
ALMOST_EMPTY  output  1  COUNT <= AE_THRESH.
COUNT  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
OVERFLOW  output  1  sticky: a write was attempted while full.
UNDERFLOW  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (RST=1 at a clock edge; takes priority over everything, including mid-burst):
  - wr_ptr, rd_ptr and COUNT go to 0.
  - OVERFLOW, UNDERFLOW and R_VALID go to 0; Data_out goes to 0 in standard mode.
  - EMPTY_flag=1, FULL_flag=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_THRESH==0 ? 1 : 0).
  - Memory contents are not cleared.
- Internal pointers are ADDR_WIDTH wide and wrap DEPTH-1 -> 0 with no special handling. COUNT is a separate registered counter.
- Write is accepted iff W_EN=1 and FULL_flag=0. The word is stored at mem[wr_ptr] and wr_ptr increments.
- Read is accepted iff R_EN=1 and EMPTY_flag=0. rd_ptr increments. Acceptance is judged on the flags as they stand before the edge.
- COUNT update per edge:
  - +1 on write only.
  - -1 on read only.
  - unchanged on both accepted or neither.
- Full + W_EN + R_EN: the read is accepted and the write is rejected. COUNT becomes DEPTH-1 and OVERFLOW sets.
- Empty + W_EN + R_EN: the write is accepted and the read is rejected. COUNT becomes 1 and UNDERFLOW sets.
- Status flags are decoded from the registered COUNT only and update in the same cycle as COUNT.
- OVERFLOW sets on W_EN while full; UNDERFLOW sets on R_EN while empty. Both hold until ERR_CLR=1 or RST.
  - If ERR_CLR and a new error occur in the same cycle, the set wins.
- Standard mode (FWFT=0):
  - An accepted read registers mem[rd_ptr] into Data_out at that edge, so read latency is 1 cycle.
  - R_VALID=1 for exactly the cycle after each accepted read, otherwise 0.
  - Data_out holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - Data_out = mem[rd_ptr] continuously (asynchronous array read), so zero latency.
  - R_VALID = ~EMPTY_flag.
  - R_EN acknowledges the presented word and advances to the next one.
  - A word written into an empty FIFO appears on Data_out, with R_VALID=1, the cycle after the write edge.
- Writing to the entry currently being read is impossible. The full/empty rules guarantee this, so no read/write collision bypass is required.

Test Plan:
1. DEPTH=16, FWFT=0: reset, write 0x01..0x10 in consecutive cycles -> FULL_flag=1 and COUNT=16 after the 16th edge; ALMOST_FULL first high at COUNT=14; then read 16 -> Data_out 0x01..0x10 in order, each one cycle after R_EN, with R_VALID pulses; EMPTY_flag=1 at end.
2. Full FIFO, W_EN=1 and R_EN=1 in one cycle -> COUNT=15, OVERFLOW=1, the write data is not stored; ERR_CLR=1 for one cycle -> OVERFLOW=0.
3. Empty FIFO, R_EN=1 alone -> UNDERFLOW=1, COUNT stays 0, R_VALID stays 0; then W_EN+R_EN together -> COUNT=1, Data_in retained.
4. Wrap-around: 40 cycles of continuous simultaneous write/read at COUNT=3 (pointers wrap twice) -> COUNT stays 3, read data matches the write sequence exactly, no error flags set.
5. FWFT=1: write 0xA5 into an empty FIFO -> the next cycle Data_out=0xA5, R_VALID=1 with no R_EN; pulse R_EN -> EMPTY_flag=1, R_VALID=0.
6. Half-full FIFO (COUNT=8), assert RST for one cycle while W_EN=R_EN=1 -> COUNT=0, EMPTY_flag=1, errors cleared, the write in that cycle is not accepted.
